// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped branch target buffer with saturating direction counters
module btb_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc,
    output logic              predicted,
    output logic [ADDR_W-1:0] predicted_address,
    output logic              hit,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_taken,
    input  logic              invalidate_all
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             upd_en;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_next;

    // Byte-offset bits never select an entry; tie them off so they are visibly unused.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{pc[1:0], update_pc[1:0]};

    assign l_idx = pc[IDX_W+1:2];
    assign l_tag = pc[ADDR_W-1:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[ADDR_W-1:IDX_W+2];

    // Lookup: purely from the fetch PC and stored state, never from update inputs.
    always_comb begin
        hit               = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        predicted         = hit && ctr_q[l_idx][CTR_W-1];
        predicted_address = hit ? target_q[l_idx] : '0;
    end

    // Training decode: hit detection on the update index and the saturated counter step.
    always_comb begin
        upd_en   = enable && update_valid && !invalidate_all;
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        ctr_cur  = ctr_q[u_idx];
        ctr_next = ctr_cur;
        if (update_taken) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != '0) ctr_next = ctr_cur - CTR_W'(1);
        end
    end

    // Valid bits and counters: reset, global invalidate, allocate or train.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
        end else if (enable) begin
            if (invalidate_all) begin
                valid_q <= '0;
            end else if (update_valid) begin
                if (u_hit) begin
                    ctr_q[u_idx] <= ctr_next;
                end else if (update_taken) begin
                    valid_q[u_idx] <= 1'b1;
                    ctr_q[u_idx]   <= CTR_WEAK;
                end
            end
        end
    end

    // Tag and target storage is unreset; outputs are masked by the valid bit.
    always_ff @(posedge clk) begin
        if (!rst && upd_en && update_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= update_target;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - table-driven self-checking bench for btb_predictor
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] pc;
    logic        predicted;
    logic [31:0] predicted_address;
    logic        hit;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        invalidate_all;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btb_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .pc                (pc),
        .predicted         (predicted),
        .predicted_address (predicted_address),
        .hit               (hit),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_target     (update_target),
        .update_taken      (update_taken),
        .invalidate_all    (invalidate_all)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        inv;
        logic        chk;
        logic        hit;
        logic        pred;
        logic [31:0] addr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [31:0] p,
                                input logic uv, input logic [31:0] upc, input logic [31:0] ut,
                                input logic tk, input logic inv, input logic chk,
                                input logic h, input logic pr, input logic [31:0] a);
        vec_t v;
        v.rst = r; v.en = e; v.pc = p; v.uv = uv; v.upc = upc; v.utgt = ut;
        v.utk = tk; v.inv = inv; v.chk = chk; v.hit = h; v.pred = pr; v.addr = a;
        return v;
    endfunction

    // Lookup-only vector with the pipeline enabled
    function automatic vec_t lk(input logic [31:0] p, input logic h, input logic pr,
                                input logic [31:0] a);
        return mk(0, 1, p, 0, 0, 0, 0, 0, 1, h, pr, a);
    endfunction

    // Training vector with lookup at the same PC
    function automatic vec_t tr(input logic [31:0] p, input logic [31:0] ut, input logic tk,
                                input logic h, input logic pr, input logic [31:0] a);
        return mk(0, 1, p, 1, p, ut, tk, 0, 1, h, pr, a);
    endfunction

    task automatic apply_vec(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; enable = v.en; pc = v.pc; update_valid = v.uv; update_pc = v.upc;
        update_target = v.utgt; update_taken = v.utk; invalidate_all = v.inv;
        #1;
        if (v.chk) begin
            checks++;
            if (hit !== v.hit) begin
                errors++;
                $display("FAIL %s hit: got %b expected %b", name, hit, v.hit);
            end
            checks++;
            if (predicted !== v.pred) begin
                errors++;
                $display("FAIL %s predicted: got %b expected %b", name, predicted, v.pred);
            end
            checks++;
            if (predicted_address !== v.addr) begin
                errors++;
                $display("FAIL %s predicted_address: got %h expected %h", name,
                         predicted_address, v.addr);
            end
        end
    endtask

    initial begin
        rst = 1; enable = 0; pc = 0; update_valid = 0; update_pc = 0;
        update_target = 0; update_taken = 0; invalidate_all = 0;

        vq.push_back(mk(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(lk(32'h40, 0, 0, 0));                        // reset state
        vq.push_back(tr(32'h40, 32'h100, 1, 0, 0, 0));            // allocate, pre-update view
        vq.push_back(lk(32'h40, 1, 1, 32'h100));                  // ctr=2
        vq.push_back(tr(32'h40, 32'h100, 0, 1, 1, 32'h100));      // ctr->1
        vq.push_back(tr(32'h40, 32'h100, 1, 1, 0, 32'h100));      // ctr->2
        vq.push_back(tr(32'h40, 32'h100, 1, 1, 1, 32'h100));      // ctr->3
        vq.push_back(tr(32'h40, 32'h100, 1, 1, 1, 32'h100));      // stays 3
        vq.push_back(tr(32'h40, 32'h100, 0, 1, 1, 32'h100));      // ctr->2
        vq.push_back(tr(32'h40, 32'h100, 0, 1, 1, 32'h100));      // ctr->1
        vq.push_back(lk(32'h40, 1, 0, 32'h100));
        vq.push_back(tr(32'h80, 32'h200, 1, 0, 0, 0));            // alias evicts idx 0
        vq.push_back(lk(32'h40, 0, 0, 0));
        vq.push_back(lk(32'h80, 1, 1, 32'h200));
        vq.push_back(mk(0, 1, 32'h80, 1, 32'hC0, 32'h300, 0, 0, 1, 1, 1, 32'h200));
        vq.push_back(lk(32'h80, 1, 1, 32'h200));
        vq.push_back(lk(32'hC0, 0, 0, 0));
        vq.push_back(tr(32'h80, 32'h280, 1, 1, 1, 32'h200));      // hit taken retargets
        vq.push_back(lk(32'h80, 1, 1, 32'h280));
        vq.push_back(mk(0, 0, 32'h44, 1, 32'h44, 32'h144, 1, 0, 1, 0, 0, 0));
        vq.push_back(lk(32'h44, 0, 0, 0));                        // nothing created
        vq.push_back(tr(32'h44, 32'h144, 1, 0, 0, 0));            // no bypass
        vq.push_back(lk(32'h44, 1, 1, 32'h144));
        vq.push_back(mk(0, 0, 32'h44, 0, 0, 0, 0, 1, 1, 1, 1, 32'h144));
        vq.push_back(lk(32'h44, 1, 1, 32'h144));                  // invalidate ignored
        vq.push_back(lk(32'h47, 1, 1, 32'h144));                  // offset bits ignored
        vq.push_back(tr(32'h4C, 32'h400, 1, 0, 0, 0));
        vq.push_back(mk(0, 1, 32'h80, 1, 32'h48, 32'h500, 1, 1, 1, 1, 1, 32'h280));
        vq.push_back(lk(32'h80, 0, 0, 0));
        vq.push_back(lk(32'h44, 0, 0, 0));
        vq.push_back(lk(32'h4C, 0, 0, 0));
        vq.push_back(lk(32'h48, 0, 0, 0));                        // update was dropped
        vq.push_back(tr(32'h48, 32'h500, 1, 0, 0, 0));
        vq.push_back(mk(1, 1, 32'h48, 1, 32'h50, 32'h600, 1, 0, 1, 1, 1, 32'h500));
        vq.push_back(lk(32'h48, 0, 0, 0));                        // reset cleared entry
        vq.push_back(lk(32'h50, 0, 0, 0));                        // pending update discarded

        foreach (vq[i]) apply_vec(vq[i], $sformatf("vec%0d", i));

        // Lower-bound saturation: three not-taken from weakly taken must hold at 0.
        apply_vec(tr(32'h54, 32'h700, 1, 0, 0, 0), "sat_alloc");
        apply_vec(tr(32'h54, 32'h700, 0, 1, 1, 32'h700), "sat_nt1");
        apply_vec(tr(32'h54, 32'h700, 0, 1, 0, 32'h700), "sat_nt2");
        apply_vec(tr(32'h54, 32'h700, 0, 1, 0, 32'h700), "sat_nt3");
        apply_vec(tr(32'h54, 32'h700, 1, 1, 0, 32'h700), "sat_t1");
        apply_vec(tr(32'h54, 32'h700, 1, 1, 0, 32'h700), "sat_t2");
        apply_vec(lk(32'h54, 1, 1, 32'h700), "sat_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer with per-entry saturating direction counters. It sits in the fetch stage of the RV32I pipeline. It gives the PC mux a combinational predicted target and taken flag for the current fetch PC. It is trained from the decode stage once a branch or jump resolves. Compared with a valid-bit-only BTB, it adds configurable depth, counter hysteresis, an alias-safe tag compare, a global invalidate, and a stall-aware `enable`.

## Interface
Parameters:
- ADDR_W, 32, PC/target width in bits
- ENTRIES, 16, number of direct-mapped entries; power of two, ≥2
- CTR_W, 2, width of each saturating direction counter; ≥1
- Derived IDX_W = log2(ENTRIES); TAG_W = ADDR_W − IDX_W − 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  global pipeline enable; when low, no state changes
- pc  in  ADDR_W  current fetch PC (lookup)
- predicted  out  1  predict taken for `pc`
- predicted_address  out  ADDR_W  predicted target for `pc`
- hit  out  1  valid entry with matching tag for `pc`, regardless of direction
- update_valid  in  1  a resolved branch or jump is present in decode
- update_pc  in  ADDR_W  PC of the resolved instruction (IF/ID PC)
- update_target  in  ADDR_W  resolved target address
- update_taken  in  1  resolved direction; jumps always drive 1
- invalidate_all  in  1  clear all entries (e.g. after instruction-memory rewrite)

## Operation
- Index and tag:
  - idx(a) = a[IDX_W+1:2]
  - tag(a) = a[ADDR_W−1:IDX_W+2]
  - a[1:0] is ignored.
- Entry state: valid (1), tag (TAG_W), target (ADDR_W), ctr (CTR_W).
- Lookup is purely combinational from `pc` and current state:
  - hit = valid[idx] && tag[idx]==tag(pc)
  - predicted = hit && ctr[idx][CTR_W−1]
  - predicted_address = hit ? target[idx] : 0
- Update, applied at the clock edge when enable && update_valid && !invalidate_all, for entry u = idx(update_pc):
  - Miss (invalid or tag mismatch), taken: allocate. Set valid=1, tag=tag(update_pc), target=update_target, ctr=2^(CTR_W−1) (weakly taken). This overwrites any aliased entry.
  - Miss, not taken: no change. Not-taken branches are not allocated.
  - Hit, taken: ctr=min(ctr+1, 2^CTR_W−1); target=update_target.
  - Hit, not taken: ctr=max(ctr−1, 0). The entry stays valid and the target is kept.
- invalidate_all (when enable=1): all valid bits are cleared at the edge. It has priority over a same-cycle update; that update is dropped.
- Only valid bits and counters are reset. Tag and target storage need no reset, because outputs are masked by valid.

## Timing
- Lookup latency is 0 cycles (same-cycle combinational). There is no path from the update inputs to the lookup outputs.
- Updates become visible to lookup on the cycle after the training edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no bypass.
- enable=0: updates and invalidate_all are ignored. Lookup outputs still track `pc` combinationally.
- Reset (rst=1 at an edge): all valid=0 and all ctr=0. Outputs read hit=0, predicted=0, predicted_address=0 from the first cycle after the edge. Reset overrides enable, update and invalidate.
- A reset asserted while an update is pending discards that update.
- Counter saturation: no wrap at either bound. With CTR_W=1 the counter behaves as a last-outcome bit.

## Test plan
- Reset then lookup: rst=1 for 1 cycle, then pc=0x40 -> hit=0, predicted=0, predicted_address=0.
- Allocate then predict: update pc=0x40, target=0x100, taken=1. Next cycle pc=0x40 -> hit=1, predicted=1, predicted_address=0x100, ctr=2.
- Hysteresis: after allocation, apply one not-taken update -> ctr=1, predicted=0, hit=1. Apply two taken updates -> ctr=3, predicted=1. A third taken update keeps ctr=3 (saturation).
- Alias eviction (ENTRIES=16): allocate pc=0x40 (idx 0, tag 1), then apply a taken update at pc=0x80 (idx 0, tag 2), target=0x200. Then pc=0x40 -> hit=0, and pc=0x80 -> predicted_address=0x200. A not-taken miss at pc=0xC0 leaves idx 0 unchanged.
- Enable and same-cycle behaviour:
  - With enable=0, a taken update at pc=0x44 -> no entry is created.
  - With enable=1, an update and lookup at pc=0x44 in the same cycle -> hit=0 that cycle and hit=1 the next.
- invalidate_all: with 3 entries valid, assert invalidate_all together with a taken update at pc=0x48 -> the next cycle shows hit=0 for all three PCs and for 0x48.
